tm1638_frame_scheduler: RTL and testbench

//  Sequences periodic TM1638 refresh frames on the LED&KEY board:
//  - Write mode command, 7-segment and LED RAM, display control, key scan.
//  - Issues commands one byte at a time to the TM1638 serial byte engine over a valid/ready

---
 rtl/tm1638_frame_scheduler_if.sv | 22 ++
 rtl/tm1638_frame_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_tm1638_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_frame_scheduler_if.sv
// Byte request / read-return channel between the frame scheduler and the TM1638 serial byte engine.
// Zero latency; pure wiring.
// The engine stalls the scheduler by holding tx_ready low; rx_valid is a one-cycle pulse per completed read.
interface tm1638_frame_scheduler_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_read;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_byte;

  modport master (
    output tx_valid, tx_byte, tx_read, tx_last,
    input  tx_ready, rx_valid, rx_byte
  );

  modport slave (
    input  tx_valid, tx_byte, tx_read, tx_last,
    output tx_ready, rx_valid, rx_byte
  );
endinterface

// File: rtl/tm1638_frame_scheduler.sv
// Periodic TM1638 refresh: mode, address, 16 RAM bytes, display control, then a 4-byte key scan.
// Frame starts one cycle after the period tick (or after the previous frame if a tick was pending); max one write byte per cycle.
// Every byte is held on the bus until the engine takes it; each read waits for rx_valid before the next is issued.
module tm1638_frame_scheduler #(
  parameter int clk_mhz    = 50,
  parameter int refresh_hz = 200,
  parameter int w_digit    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*w_digit-1:0]   seg,
  input  logic [7:0]             ledr,
  input  logic [2:0]             brightness,
  input  logic                   display_en,
  tm1638_frame_scheduler_if.master bus,
  output logic [7:0]             keys,
  output logic                   keys_valid,
  output logic                   busy
);

  localparam int unsigned period_cycles = clk_mhz * 1_000_000 / refresh_hz;
  localparam int          cnt_w         = (period_cycles > 1) ? $clog2(period_cycles) : 1;
  localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(period_cycles - 1);

  typedef enum logic [3:0] {
    IDLE, MODE, ADDR, DATA, CTRL, KCMD, KREAD, KWAIT, DONE
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] period_cnt;
  logic             tick;
  logic             pending;
  logic [3:0]       byte_cnt;
  logic [7:0]       key_acc;
  logic [63:0]      seg_pad;
  logic [63:0]      seg_s;
  logic [7:0]       ledr_s;
  logic [2:0]       bright_s;
  logic             en_s;
  logic             accept;
  logic             unused_rx;

  assign tick   = (period_cnt == cnt_max);
  assign accept = bus.tx_valid & bus.tx_ready;

  // Only bits 0 and 4 of each scan byte carry key state on this board.
  assign unused_rx = ^{bus.rx_byte[7:5], bus.rx_byte[3:1]};

  // Widen seg to all eight grids; grids beyond w_digit are blanked.
  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < w_digit) begin : g_on
      assign seg_pad[8*g +: 8] = seg[8*g +: 8];
    end else begin : g_off
      assign seg_pad[8*g +: 8] = 8'h00;
    end
  end

  // RAM byte k: even addresses are grid segments, odd addresses are the single LED bit.
  function automatic logic [7:0] data_byte(input logic [3:0] k);
    if (k[0]) return {7'b0, ledr_s[k[3:1]]};
    return seg_s[{k[3:1], 3'b000} +: 8];
  endfunction

  // Free-running period counter; preloaded to its last value so a frame starts right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_cnt <= cnt_max;
    else     period_cnt <= tick ? '0 : period_cnt + 1'b1;
  end

  // Frame sequencer: owns every byte presented to the engine and the key result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= 1'b0;
      byte_cnt     <= 4'd0;
      key_acc      <= 8'h00;
      seg_s        <= 64'h0;
      ledr_s       <= 8'h00;
      bright_s     <= 3'd0;
      en_s         <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_byte  <= 8'h00;
      bus.tx_read  <= 1'b0;
      bus.tx_last  <= 1'b0;
      keys         <= 8'h00;
      keys_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      keys_valid <= 1'b0;
      // Ticks during a frame collapse into a single pending start.
      if (tick && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (tick || pending) begin
            pending      <= 1'b0;
            seg_s        <= seg_pad;
            ledr_s       <= ledr;
            bright_s     <= brightness;
            en_s         <= display_en;
            busy         <= 1'b1;
            state        <= MODE;
            byte_cnt     <= 4'd0;
            bus.tx_valid <= 1'b1;
            bus.tx_byte  <= 8'h40;
            bus.tx_read  <= 1'b0;
            bus.tx_last  <= 1'b1;
          end
        end
        MODE: begin
          if (accept) begin
            state       <= ADDR;
            byte_cnt    <= 4'd0;
            bus.tx_byte <= 8'hC0;
            bus.tx_last <= 1'b0;
          end
        end
        ADDR: begin
          if (accept) begin
            state       <= DATA;
            byte_cnt    <= 4'd0;
            bus.tx_byte <= data_byte(4'd0);
            bus.tx_last <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            if (byte_cnt == 4'd15) begin
              state       <= CTRL;
              byte_cnt    <= 4'd0;
              bus.tx_byte <= {4'b1000, en_s, bright_s};
              bus.tx_last <= 1'b1;
            end else begin
              byte_cnt    <= byte_cnt + 4'd1;
              bus.tx_byte <= data_byte(byte_cnt + 4'd1);
              bus.tx_last <= (byte_cnt == 4'd14);
            end
          end
        end
        CTRL: begin
          if (accept) begin
            state       <= KCMD;
            byte_cnt    <= 4'd0;
            bus.tx_byte <= 8'h42;
            bus.tx_last <= 1'b0;
          end
        end
        KCMD: begin
          if (accept) begin
            state       <= KREAD;
            byte_cnt    <= 4'd0;
            key_acc     <= 8'h00;
            bus.tx_byte <= 8'h00;
            bus.tx_read <= 1'b1;
            bus.tx_last <= 1'b0;
          end
        end
        KREAD: begin
          // Hold off the next read until the engine returns this one.
          if (accept) begin
            state        <= KWAIT;
            bus.tx_valid <= 1'b0;
          end
        end
        KWAIT: begin
          if (bus.rx_valid) begin
            key_acc[{1'b0, byte_cnt[1:0]}] <= bus.rx_byte[0];
            key_acc[{1'b1, byte_cnt[1:0]}] <= bus.rx_byte[4];
            if (byte_cnt == 4'd3) begin
              state       <= DONE;
              bus.tx_read <= 1'b0;
              bus.tx_last <= 1'b0;
            end else begin
              state        <= KREAD;
              byte_cnt     <= byte_cnt + 4'd1;
              bus.tx_valid <= 1'b1;
              bus.tx_last  <= (byte_cnt == 4'd2);
            end
          end
        end
        DONE: begin
          keys       <= key_acc;
          keys_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_frame_scheduler.sv
// Directed bench for tm1638_frame_scheduler with a behavioural byte engine (ready stalls, delayed read returns).
// Period is 1000 cycles (1 MHz / 1 kHz); six grids are driven so grids 6 and 7 must go out blank.
// Each frame's byte stream, key result and start time are compared against hand-computed values.
module tb_tm1638_frame_scheduler;

  logic        clk;
  logic        rst;
  logic [47:0] seg;
  logic [7:0]  ledr;
  logic [2:0]  brightness;
  logic        display_en;
  logic [7:0]  keys;
  logic        keys_valid;
  logic        busy;

  tm1638_frame_scheduler_if bus();

  tm1638_frame_scheduler #(.clk_mhz(1), .refresh_hz(1000), .w_digit(6)) dut (
    .clk(clk), .rst(rst), .seg(seg), .ledr(ledr), .brightness(brightness),
    .display_en(display_en), .bus(bus), .keys(keys), .keys_valid(keys_valid), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_frame = 0;
  int t_done = 0;
  int kv_long = 0;
  int stall_bad = 0;
  int early_keys = 0;
  logic busy_q = 1'b0;
  logic kv_q = 1'b0;
  logic aborted;
  logic busy_at_done;
  logic [9:0] got[$];
  logic [9:0] cur;

  assign cur = {bus.tx_read, bus.tx_last, bus.tx_byte};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Frame start = rising edge of busy; keys_valid must never be two cycles wide.
  always @(negedge clk) begin
    if (busy && !busy_q) t_frame = cyc;
    if (keys_valid && kv_q) kv_long++;
    busy_q = busy;
    kv_q   = keys_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_new();
    seg        = 48'h11_22_33_44_55_66;
    ledr       = 8'h5A;
    brightness = 3'd5;
    display_en = 1'b1;
  endtask

  // Plays the byte engine for one frame; stops at keys_valid, or at the abort point with rst raised.
  task automatic run_frame(input int rdy_pct, input int dly_min, input int dly_max,
                           input logic [31:0] rx_word, input int stall,
                           input int change_at, input int abort_at);
    int guard = 0;
    int wcnt = -1;
    int ridx = 0;
    int ts = 0;
    logic started = 1'b0;
    logic prev_stall = 1'b0;
    logic [9:0] prev = '0;
    logic [7:0] keys0;
    logic r;
    logic fin = 1'b0;
    got.delete();
    stall_bad = 0;
    early_keys = 0;
    aborted = 1'b0;
    keys0 = keys;
    while (!fin && guard < 5000) begin
      @(negedge clk);
      guard++;
      bus.rx_valid = 1'b0;
      if (prev_stall && !(bus.tx_valid && cur == prev)) stall_bad++;
      if (bus.tx_valid && !started) begin
        started = 1'b1;
        ts = cyc;
      end
      if (keys_valid) begin
        fin = 1'b1;
        t_done = cyc;
        busy_at_done = busy;
        bus.tx_ready = 1'b0;
      end else begin
        if (keys !== keys0) early_keys++;
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = rx_word[8*ridx +: 8];
            ridx++;
            wcnt = -1;
          end
        end
        if (abort_at > 0 && got.size() == abort_at && bus.tx_valid) begin
          bus.tx_ready = 1'b0;
          rst = 1'b1;
          #1;
          fin = 1'b1;
          aborted = 1'b1;
        end else begin
          r = (started && (cyc - ts) < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
          bus.tx_ready = r;
          if (bus.tx_valid && r) begin
            got.push_back(cur);
            if (bus.tx_read) wcnt = $urandom_range(dly_max, dly_min);
            if (got.size() == change_at) apply_new();
          end
          prev_stall = bus.tx_valid && !r;
          prev = cur;
        end
      end
    end
    check("frame_finished", fin, 1'b1);
  endtask

  // Expected stream: fixed framing around the 16 hand-computed RAM bytes (k=0 in the top byte).
  task automatic check_frame(input string tag, input logic [127:0] data, input logic [7:0] ctrl);
    logic [9:0] e [24];
    int bad = 0;
    logic [9:0] g;
    e[0]  = {2'b01, 8'h40};
    e[1]  = {2'b00, 8'hC0};
    for (int k = 0; k < 16; k++) e[2+k] = {1'b0, (k == 15), data[8*(15-k) +: 8]};
    e[18] = {2'b01, ctrl};
    e[19] = {2'b00, 8'h42};
    for (int j = 0; j < 4; j++) e[20+j] = {1'b1, (j == 3), 8'h00};
    check({tag, "_len"}, got.size(), 24);
    for (int i = 23; i >= 0; i--) if (i >= got.size() || got[i] !== e[i]) bad = i;
    g = (bad < got.size()) ? got[bad] : 10'h3FF;
    check($sformatf("%s_byte%0d", tag, bad), g, e[bad]);
  endtask

  localparam logic [127:0] D_ZERO = 128'h0;
  localparam logic [127:0] D_OLD  = 128'h3F015B00_00000000_00000600_00000001;
  localparam logic [127:0] D_NEW  = 128'h66005501_44003301_22011100_00010000;

  int rel, s1, s2, s3, s4, s6, d4;

  initial begin
    rst = 1'b1;
    seg = 48'h0;
    ledr = 8'h00;
    brightness = 3'd7;
    display_en = 1'b1;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_fields", cur, 10'h000);
    check("rst_keys", keys, 8'h00);
    check("rst_keys_valid", keys_valid, 1'b0);
    check("rst_busy", busy, 1'b0);

    rst = 1'b0;
    rel = cyc;

    // Frame 1: all-zero display, full brightness, no keys.
    run_frame(100, 1, 1, 32'h0, 0, 0, 0);
    s1 = t_frame;
    check("f1_start", s1, rel + 1);
    check_frame("f1", D_ZERO, 8'h8F);
    check("f1_keys", keys, 8'h00);
    check("f1_busy_done", busy_at_done, 1'b0);

    // Frame 2: patterned grids and LEDs, display off, key scan 01,10,00,11.
    seg = 48'h06_00_00_00_5B_3F;
    ledr = 8'h81;
    brightness = 3'd3;
    display_en = 1'b0;
    run_frame(100, 1, 3, 32'h11001001, 0, 0, 0);
    s2 = t_frame;
    check("f2_start", s2, s1 + 1000);
    check_frame("f2", D_OLD, 8'h83);
    check("f2_keys", keys, 8'hA9);
    check("f2_keys_early", early_keys, 0);

    // Frame 3: 30% ready, slow reads; stream and hold behaviour unchanged.
    run_frame(30, 5, 20, 32'hEFFE11EE, 0, 0, 0);
    s3 = t_frame;
    check("f3_start", s3, s2 + 1000);
    check_frame("f3", D_OLD, 8'h83);
    check("f3_stall_stable", stall_bad, 0);
    check("f3_keys", keys, 8'h6A);
    check("f3_keys_early", early_keys, 0);

    // Frame 4: engine stalls 1500 cycles on the first byte, so a tick lands mid-frame.
    run_frame(100, 1, 2, 32'h0, 1500, 0, 0);
    s4 = t_frame;
    d4 = t_done;
    check("f4_start", s4, s3 + 1000);
    check_frame("f4", D_OLD, 8'h83);
    check("f4_stall_stable", stall_bad, 0);
    check("f4_keys", keys, 8'h00);

    // Frame 5: the pending tick fires right after frame 4.
    run_frame(100, 1, 2, 32'h11001001, 0, 0, 0);
    check("f5_start", t_frame, d4 + 1);
    check_frame("f5", D_OLD, 8'h83);
    check("f5_keys", keys, 8'hA9);

    // Frame 6: back on the tick grid (no extra frame); inputs change mid-DATA.
    run_frame(100, 1, 2, 32'h0, 0, 6, 0);
    s6 = t_frame;
    check("f6_start", s6, s4 + 2000);
    check_frame("f6", D_OLD, 8'h83);
    check("f6_keys", keys, 8'h00);

    // Frame 7: picks up the new inputs.
    run_frame(100, 1, 2, 32'h11001001, 0, 0, 0);
    check("f7_start", t_frame, s6 + 1000);
    check_frame("f7", D_NEW, 8'h8D);
    check("f7_keys", keys, 8'hA9);

    // Frame 8: reset while the second key read is on the bus.
    run_frame(100, 1, 2, 32'h0, 0, 0, 21);
    check("f8_aborted", aborted, 1'b1);
    check("f8_rst_tx_valid", bus.tx_valid, 1'b0);
    check("f8_rst_keys", keys, 8'h00);
    check("f8_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;

    // Frame 9: restart from the mode byte immediately after release.
    run_frame(100, 1, 2, 32'h00110000, 0, 0, 0);
    check("f9_start", t_frame, rel + 1);
    check_frame("f9", D_NEW, 8'h8D);
    check("f9_keys", keys, 8'h44);

    check("keys_valid_width", kv_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
